// File: rtl/sr_reg_bank_pkg.sv
// sr_pkg: shared definitions for the SR status-flag register bank.
//   SR_HOLD / SR_SET_DOM / SR_RST_DOM / SR_TOGGLE : policy codes for S=R=1
//   sr_next(q, s, r, mode)                         : one-channel next state
package sr_pkg;

    localparam logic [1:0] SR_HOLD    = 2'd0;
    localparam logic [1:0] SR_SET_DOM = 2'd1;
    localparam logic [1:0] SR_RST_DOM = 2'd2;
    localparam logic [1:0] SR_TOGGLE  = 2'd3;

    // Next state of a single SR channel, assuming the update is enabled.
    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input logic [1:0] mode);
        logic nq;
        nq = q;
        case ({s, r})
            2'b00: nq = q;
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            default: begin
                case (mode)
                    SR_SET_DOM: nq = 1'b1;
                    SR_RST_DOM: nq = 1'b0;
                    SR_TOGGLE:  nq = ~q;
                    default:    nq = q;
                endcase
            end
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_reg_bank_cell.sv
// sr_cell: one SR channel with registered q/qbar and registered edge pulses.
//   clk, reset : clock, synchronous active-high reset
//   i_en       : update enable (hold when 0)
//   i_s, i_r   : set / reset inputs
//   o_q, o_qbar: registered state and its complement
//   o_rise     : one-cycle pulse on a 0->1 change of q
//   o_fall     : one-cycle pulse on a 1->0 change of q
module sr_cell
    import sr_pkg::*;
#(
    parameter logic [1:0] FORBID_MODE = SR_HOLD,
    parameter logic       RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_qbar,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;
    logic r_qbar;
    logic r_rise;
    logic r_fall;
    logic w_q_nxt;

    // When disabled the next state equals the current one, so the pulse
    // equations below naturally produce zero.
    assign w_q_nxt = i_en ? sr_next(r_q, i_s, i_r, FORBID_MODE) : r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= RESET_VAL;
            r_qbar <= ~RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_qbar <= ~w_q_nxt;
            r_rise <= ~r_q & w_q_nxt;
            r_fall <= r_q & ~w_q_nxt;
        end
    end

    assign o_q    = r_q;
    assign o_qbar = r_qbar;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/sr_reg_bank.sv
// sr_reg_bank: WIDTH independent SR flip-flops with a selectable S=R=1
// policy, plus a sticky forbidden-input flag and a saturating event counter.
//   clk, reset      : clock, synchronous active-high reset
//   en              : update enable for all channels and event recording
//   s, r            : per-channel set / reset
//   clr_err         : clears forbid_err / forbid_cnt (a same-cycle event wins)
//   q, qbar         : registered state and complement
//   q_rise, q_fall  : registered one-cycle change pulses
//   forbid_err      : sticky flag, set by any enabled cycle with s&r != 0
//   forbid_cnt      : saturating count of such cycles
module sr_reg_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [1:0]       FORBID_MODE = SR_HOLD,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             forbid_err,
    output logic [CNT_W-1:0] forbid_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_forbid;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        sr_cell #(
            .FORBID_MODE (FORBID_MODE),
            .RESET_VAL   (RESET_VAL[g])
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .i_en   (en),
            .i_s    (s[g]),
            .i_r    (r[g]),
            .o_q    (q[g]),
            .o_qbar (qbar[g]),
            .o_rise (q_rise[g]),
            .o_fall (q_fall[g])
        );
    end

    // Any number of forbidden channels in one cycle is a single event.
    assign w_forbid = en & (|(s & r));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (w_forbid) begin
            r_err <= 1'b1;
            // A simultaneous clear restarts the count at this event.
            if (clr_err)
                r_cnt <= CNT_ONE;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_ONE;
        end else if (clr_err) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end
    end

    assign forbid_err = r_err;
    assign forbid_cnt = r_cnt;

endmodule
